lb_frame_feed_ctrl: RTL and testbench

Frame-level sequencer for the 4-line line-buffer window generator. It pulls pixels from an upstream valid/ready source and meters them into the line-buffer's pixel input.
- Prime phase: pushes PRIME_LINES rows.
- Steady state: releases exactly one further row per line-buffer interrupt.
- End of frame: counts interrupts until every output window row of the frame has been produced, then flags frame done.

---
 rtl/lb_frame_feed_ctrl.sv | 144 ++++++++++++++
 tb/tb_lb_frame_feed_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lb_frame_feed_ctrl.sv
// Frame sequencer feeding the 4-line line-buffer: primes rows, then releases one row per interrupt.
// Optional zero-row padding above/below the frame is enabled by defining LB_FEED_ZERO_PAD_EN.
module lb_frame_feed_ctrl #(
    parameter int unsigned IMG_W       = 256,
    parameter int unsigned IMG_H       = 256,
    parameter int unsigned PRIME_LINES = 4,
    parameter int unsigned PIX_W       = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic [PIX_W-1:0]           i_src_data,
    input  logic                       i_src_valid,
    output logic                       o_src_ready,
    output logic [PIX_W-1:0]           o_lb_pixel_data,
    output logic                       o_lb_pixel_valid,
    input  logic                       i_lb_intr,
    output logic                       o_busy,
    output logic                       o_frame_done,
    output logic [$clog2(IMG_H+3)-1:0] o_rows_out
);

    localparam int unsigned ROW_W = $clog2(IMG_H + 3);
    localparam int unsigned COL_W = $clog2(IMG_W);
`ifdef LB_FEED_ZERO_PAD_EN
    localparam int unsigned ROWS_IN = IMG_H + 2;
`else
    localparam int unsigned ROWS_IN = IMG_H;
`endif
    localparam int unsigned ROWS_OUT = ROWS_IN - 2;

    localparam logic [ROW_W-1:0] RowsInC   = ROW_W'(ROWS_IN);
    localparam logic [ROW_W-1:0] RowsOutC  = ROW_W'(ROWS_OUT);
    localparam logic [ROW_W-1:0] PrimeLast = ROW_W'(PRIME_LINES - 1);
    localparam logic [COL_W-1:0] ColLast   = COL_W'(IMG_W - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StPrime = 3'd1;
    localparam logic [2:0] StWait  = 3'd2;
    localparam logic [2:0] StFeed  = 3'd3;
    localparam logic [2:0] StDrain = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [COL_W-1:0] col_cnt_q, col_cnt_d;
    logic [ROW_W-1:0] row_in_q, row_in_d;
    logic [ROW_W-1:0] credit_q, credit_d;
    logic [ROW_W-1:0] rows_out_q, rows_out_d;
    logic [PIX_W-1:0] pix_data_q, pix_data_d;
    logic             pix_valid_q, pix_valid_d;

    logic feeding, pad_row, src_ready, push, row_end, row_start, intr_act, credit_inc;

    assign feeding = (state_q == StPrime) || (state_q == StFeed);
`ifdef LB_FEED_ZERO_PAD_EN
    // First and last input rows are synthesized zeros; the source is held off during them.
    assign pad_row = feeding && ((row_in_q == '0) || (row_in_q == RowsInC - 1'b1));
`else
    assign pad_row = 1'b0;
`endif
    assign src_ready  = feeding && !pad_row;
    assign push       = (src_ready && i_src_valid) || pad_row;
    assign row_end    = push && (col_cnt_q == ColLast);
    assign row_start  = push && (col_cnt_q == '0) && (state_q == StFeed);
    assign intr_act   = i_lb_intr && (state_q != StIdle);
    // Never bank more rows than the frame still has to deliver.
    assign credit_inc = intr_act &&
                        (({1'b0, row_in_q} + {1'b0, credit_q}) < {1'b0, RowsInC});

    always_comb begin
        state_d     = state_q;
        col_cnt_d   = col_cnt_q;
        row_in_d    = row_in_q;
        credit_d    = credit_q;
        rows_out_d  = rows_out_q;
        pix_data_d  = pix_data_q;
        pix_valid_d = push;

        if (push) begin
            pix_data_d = pad_row ? '0 : i_src_data;
            col_cnt_d  = row_end ? '0 : col_cnt_q + 1'b1;
            if (row_end) row_in_d = row_in_q + 1'b1;
        end

        case ({credit_inc, row_start})
            2'b10:   credit_d = credit_q + 1'b1;
            2'b01:   credit_d = credit_q - 1'b1;
            default: credit_d = credit_q;
        endcase

        if (intr_act && (rows_out_q != RowsOutC)) rows_out_d = rows_out_q + 1'b1;

        case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d    = StPrime;
                    col_cnt_d  = '0;
                    row_in_d   = '0;
                    credit_d   = '0;
                    rows_out_d = '0;
                end
            end
            StPrime: if (row_end && (row_in_q == PrimeLast)) state_d = StWait;
            StWait: begin
                if (row_in_q == RowsInC)  state_d = StDrain;
                else if (credit_q != '0)  state_d = StFeed;
            end
            StFeed: begin
                if (row_end) state_d = (row_in_d < RowsInC) ? StWait : StDrain;
            end
            StDrain: if (rows_out_q == RowsOutC) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            col_cnt_q   <= '0;
            row_in_q    <= '0;
            credit_q    <= '0;
            rows_out_q  <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            row_in_q    <= row_in_d;
            credit_q    <= credit_d;
            rows_out_q  <= rows_out_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    assign o_src_ready      = src_ready;
    assign o_lb_pixel_data  = pix_data_q;
    assign o_lb_pixel_valid = pix_valid_q;
    assign o_busy           = (state_q != StIdle);
    assign o_frame_done     = (state_q == StDone);
    assign o_rows_out       = rows_out_q;

endmodule

// File: tb/tb_lb_frame_feed_ctrl.sv
// Scoreboard bench for lb_frame_feed_ctrl (IMG_W=8, IMG_H=6, no padding).
module tb_lb_frame_feed_ctrl;

    localparam int IMG_W    = 8;
    localparam int IMG_H    = 6;
    localparam int PRIME    = 4;
    localparam int PIX_W    = 8;
    localparam int ROWS_OUT = IMG_H - 2;
    localparam int RW       = $clog2(IMG_H + 3);

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_start = 1'b0;
    logic [PIX_W-1:0] i_src_data = '0;
    logic             i_src_valid = 1'b0;
    logic             o_src_ready;
    logic [PIX_W-1:0] o_lb_pixel_data;
    logic             o_lb_pixel_valid;
    logic             i_lb_intr = 1'b0;
    logic             o_busy;
    logic             o_frame_done;
    logic [RW-1:0]    o_rows_out;

    lb_frame_feed_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PRIME_LINES(PRIME), .PIX_W(PIX_W)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_src_data(i_src_data), .i_src_valid(i_src_valid), .o_src_ready(o_src_ready),
        .o_lb_pixel_data(o_lb_pixel_data), .o_lb_pixel_valid(o_lb_pixel_valid),
        .i_lb_intr(i_lb_intr), .o_busy(o_busy), .o_frame_done(o_frame_done),
        .o_rows_out(o_rows_out)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;
    logic [PIX_W-1:0] exp_q[$];
    int acc_cnt = 0, out_pix = 0, done_cnt = 0, done_rows = 0;
    int cyc = 0, c32 = 0, c33 = 0;
    int src_pct = 0;
    bit src_en = 0;
    bit lb_abort = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Source: random data every cycle, valid at src_pct percent.
    initial begin
        forever begin
            tick();
            i_src_valid = src_en && ($urandom_range(99) < src_pct);
            i_src_data  = PIX_W'($urandom);
        end
    end

    // Monitor: every accepted pixel must come out exactly one cycle later.
    always @(negedge i_clk) begin
        cyc++;
        if (!i_rst_n) begin
            exp_q.delete();
        end else begin
            if (o_lb_pixel_valid || exp_q.size() > 0) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_pixel_valid", 32'(o_lb_pixel_valid), 0);
                end else begin
                    logic [PIX_W-1:0] e;
                    e = exp_q.pop_front();
                    chk("pixel_valid", 32'(o_lb_pixel_valid), 1);
                    chk("pixel_data", 32'(o_lb_pixel_data), 32'(e));
                end
            end
            if (o_lb_pixel_valid) out_pix++;
            if (i_src_valid && o_src_ready) begin
                exp_q.push_back(i_src_data);
                acc_cnt++;
                if (acc_cnt == 32) c32 = cyc;
                if (acc_cnt == 33) c33 = cyc;
            end
            if (o_frame_done) begin
                done_cnt++;
                done_rows = int'(o_rows_out);
            end
        end
    end

    // Line-buffer model: interrupt k needs min(k+3, IMG_H) rows written, then an 8-cycle read.
    task automatic lb_serve(input int first_k, input bit dbl_last);
        for (int k = first_k; k <= ROWS_OUT; k++) begin
            int need;
            int bound;
            need  = (k + 3 < IMG_H) ? k + 3 : IMG_H;
            bound = 0;
            while ((out_pix / IMG_W) < need && !lb_abort && bound < 2000) begin
                tick();
                bound++;
            end
            if (lb_abort) return;
            if (bound >= 2000) begin
                chk("lb_row_timeout", out_pix, need * IMG_W);
                return;
            end
            repeat (8) tick();
            i_lb_intr = 1'b1;
            tick();
            if (dbl_last && k == ROWS_OUT) tick();
            i_lb_intr = 1'b0;
        end
    endtask

    task automatic new_frame(input int pct);
        acc_cnt  = 0;
        out_pix  = 0;
        done_cnt = 0;
        done_rows = -1;
        c32 = 0;
        c33 = 0;
        src_pct = pct;
        src_en  = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic finish_frame(input string tag);
        int bound;
        bound = 0;
        while (done_cnt == 0 && bound < 3000) begin
            tick();
            bound++;
        end
        repeat (4) tick();
        chk({tag, "_src_pixels"}, acc_cnt, IMG_W * IMG_H);
        chk({tag, "_lb_pixels"}, out_pix, IMG_W * IMG_H);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_rows_out_at_done"}, done_rows, ROWS_OUT);
        chk({tag, "_busy_after"}, 32'(o_busy), 0);
        src_en = 1'b0;
        tick();
    endtask

    initial begin
        #2;
        chk("reset_busy", 32'(o_busy), 0);
        chk("reset_ready", 32'(o_src_ready), 0);
        chk("reset_valid", 32'(o_lb_pixel_valid), 0);
        chk("reset_done", 32'(o_frame_done), 0);
        chk("reset_rows_out", 32'(o_rows_out), 0);
        repeat (3) tick();
        i_rst_n = 1'b1;
        tick();

        // Interrupt and source activity in IDLE are ignored.
        src_en = 1'b1;
        src_pct = 100;
        i_lb_intr = 1'b1;
        tick();
        i_lb_intr = 1'b0;
        tick();
        chk("idle_intr_rows_out", 32'(o_rows_out), 0);
        chk("idle_busy", 32'(o_busy), 0);
        chk("idle_ready", 32'(o_src_ready), 0);
        chk("idle_accepts", acc_cnt, 0);

        // 1: prime stops after 32 pixels until the first interrupt.
        new_frame(100);
        repeat (60) tick();
        chk("t1_prime_pixels", acc_cnt, PRIME * IMG_W);
        chk("t1_wait_ready", 32'(o_src_ready), 0);
        chk("t1_wait_busy", 32'(o_busy), 1);
        chk("t1_wait_rows_out", 32'(o_rows_out), 0);
        lb_serve(1, 1'b0);
        finish_frame("t1");

        // 2: interrupt banked during PRIME sends FEED straight after the WAIT cycle.
        new_frame(100);
        repeat (4) tick();
        i_lb_intr = 1'b1;
        tick();
        i_lb_intr = 1'b0;
        chk("t2_rows_out_prime", 32'(o_rows_out), 1);
        lb_serve(2, 1'b0);
        chk("t2_prime_to_feed_gap", c33 - c32, 2);
        finish_frame("t2");

        // 3: sparse upstream valid.
        new_frame(30);
        lb_serve(1, 1'b0);
        finish_frame("t3");

        // 5: restart while busy is ignored; a back-to-back final interrupt saturates.
        new_frame(100);
        repeat (10) tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("t5_busy_after_restart", 32'(o_busy), 1);
        lb_serve(1, 1'b1);
        finish_frame("t5");

        // 4: asynchronous reset in the middle of the last row.
        new_frame(100);
        fork
            lb_serve(1, 1'b0);
            begin
                int bound;
                bound = 0;
                while (acc_cnt < 5 * IMG_W + 3 && bound < 2000) begin
                    tick();
                    bound++;
                end
                chk("t4_reach_row5", acc_cnt >= 5 * IMG_W + 3, 1);
                #2;
                i_rst_n = 1'b0;
                #1;
                chk("t4_rst_busy", 32'(o_busy), 0);
                chk("t4_rst_ready", 32'(o_src_ready), 0);
                chk("t4_rst_valid", 32'(o_lb_pixel_valid), 0);
                chk("t4_rst_data", 32'(o_lb_pixel_data), 0);
                chk("t4_rst_done", 32'(o_frame_done), 0);
                chk("t4_rst_rows_out", 32'(o_rows_out), 0);
                lb_abort = 1'b1;
            end
        join
        i_lb_intr = 1'b0;
        repeat (3) tick();
        chk("t4_no_done_after_reset", done_cnt, 0);
        i_rst_n = 1'b1;
        lb_abort = 1'b0;
        tick();
        new_frame(100);
        lb_serve(1, 1'b0);
        finish_frame("t4_clean");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
